// File: rtl/vector_change_logger.sv
// ============================================================================
// vector_change_logger : per-bit change detector feeding a show-ahead event
//                        FIFO with timestamps and sticky overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_change_logger #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [WIDTH-1:0]           vec_i,
    input  logic                       clr_ovf_i,
    input  logic                       evt_ready_i,
    output logic                       evt_valid_o,
    output logic [WIDTH-1:0]           evt_vec_o,
    output logic [WIDTH-1:0]           evt_mask_o,
    output logic [TS_WIDTH-1:0]        evt_ts_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [TS_WIDTH-1:0] ts_q;
    logic [WIDTH-1:0]    prev_q;
    logic                primed_q;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;

    logic [WIDTH-1:0]    vec_mem  [DEPTH];
    logic [WIDTH-1:0]    mask_mem [DEPTH];
    logic [TS_WIDTH-1:0] ts_mem   [DEPTH];

    logic [WIDTH-1:0] w_mask;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_valid;
    logic             w_wr;
    logic             w_drop;

    assign w_mask  = vec_i ^ prev_q;
    assign w_push  = primed_q && en_i && (w_mask != '0);
    assign w_valid = (count_q != '0);
    assign w_pop   = w_valid && evt_ready_i;
    assign w_full  = (count_q == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_wr, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_q + TS_WIDTH'(1);
            prev_q     <= vec_i;
            primed_q   <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            vec_mem[wr_ptr_q]  <= vec_i;
            mask_mem[wr_ptr_q] <= w_mask;
            ts_mem[wr_ptr_q]   <= ts_q;
        end
    end

    assign evt_valid_o = w_valid;
    assign evt_vec_o   = w_valid ? vec_mem[rd_ptr_q]  : '0;
    assign evt_mask_o  = w_valid ? mask_mem[rd_ptr_q] : '0;
    assign evt_ts_o    = w_valid ? ts_mem[rd_ptr_q]   : '0;
    assign overflow_o  = overflow_q;
    assign count_o     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_change_logger.sv
// ============================================================================
// tb_vector_change_logger : directed stimulus with a queue-based event model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vector_change_logger;

    localparam int WIDTH    = 4;
    localparam int DEPTH    = 4;
    localparam int TS_WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [3:0] vec = 4'h0;
    logic       clr_ovf = 1'b0;
    logic       ready = 1'b0;
    logic       evt_valid;
    logic [3:0] evt_vec;
    logic [3:0] evt_mask;
    logic [7:0] evt_ts;
    logic       overflow;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    vector_change_logger #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TS_WIDTH(TS_WIDTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .vec_i      (vec),
        .clr_ovf_i  (clr_ovf),
        .evt_ready_i(ready),
        .evt_valid_o(evt_valid),
        .evt_vec_o  (evt_vec),
        .evt_mask_o (evt_mask),
        .evt_ts_o   (evt_ts),
        .overflow_o (overflow),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0] v;
        logic [3:0] m;
        logic [7:0] t;
    } ev_t;

    ev_t        m_q[$];
    int         m_ts     = 0;
    logic [3:0] m_prev   = 4'h0;
    bit         m_primed = 1'b0;
    bit         m_ovf    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ts     = 0;
            m_prev   = 4'h0;
            m_primed = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            logic [3:0] chg;
            bit         push, pop, was_full;
            chg      = vec ^ m_prev;
            push     = m_primed && en && (chg != 4'h0);
            pop      = (m_q.size() > 0) && ready;
            was_full = (m_q.size() == DEPTH);
            if (pop) void'(m_q.pop_front());
            if (push && was_full && !pop) begin
                m_ovf = 1'b1;
            end else begin
                if (push) m_q.push_back('{v: vec, m: chg, t: m_ts[7:0]});
                if (clr_ovf) m_ovf = 1'b0;
            end
            m_prev   = vec;
            m_primed = 1'b1;
            m_ts     = (m_ts + 1) % 256;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_valid", {31'd0, evt_valid}, {31'd0, m_q.size() != 0});
        chk("model_count", {29'd0, count}, m_q.size());
        chk("model_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        if (m_q.size() != 0) begin
            chk("model_vec", {28'd0, evt_vec}, {28'd0, m_q[0].v});
            chk("model_mask", {28'd0, evt_mask}, {28'd0, m_q[0].m});
            chk("model_ts", {24'd0, evt_ts}, {24'd0, m_q[0].t});
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int guard;
        #1 rst = 1'b1;
        cyc(2);
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_count", {29'd0, count}, 0);
        chk("rst_vec", {28'd0, evt_vec}, 0);
        chk("rst_mask", {28'd0, evt_mask}, 0);
        chk("rst_ts", {24'd0, evt_ts}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        rst = 1'b0;

        // Baseline only: A held for three edges (ts 0..2).
        vec = 4'hA;
        cyc(3);
        chk("base_valid", {31'd0, evt_valid}, 0);
        chk("base_count", {29'd0, count}, 0);

        // Return to 0 silently, then change to 5 at the ts=5 edge.
        en = 1'b0; vec = 4'h0;
        cyc(1);
        en = 1'b1;
        cyc(1);
        vec = 4'h5;
        cyc(1);
        chk("ev1_valid", {31'd0, evt_valid}, 1);
        chk("ev1_vec", {28'd0, evt_vec}, 4'h5);
        chk("ev1_mask", {28'd0, evt_mask}, 4'h5);
        chk("ev1_ts", {24'd0, evt_ts}, 5);
        cyc(1);
        chk("ev1_hold_ts", {24'd0, evt_ts}, 5);
        chk("ev1_hold_vec", {28'd0, evt_vec}, 4'h5);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("ev1_drained", {29'd0, count}, 0);

        // Five toggles into a 4-deep FIFO: edges ts 8..12, the last is dropped.
        for (int i = 0; i < 5; i++) begin
            vec = vec ^ 4'h1;
            cyc(1);
        end
        chk("full_count", {29'd0, count}, 4);
        chk("full_ovf", {31'd0, overflow}, 1);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_ts", {24'd0, evt_ts}, 8 + i);
            chk("drain_vec", {28'd0, evt_vec}, (i % 2 == 0) ? 4'h4 : 4'h5);
            cyc(1);
        end
        ready = 1'b0;
        chk("drain_empty", {29'd0, count}, 0);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 0);

        // Refill, then push and pop together while full.
        for (int i = 0; i < 4; i++) begin
            vec = vec ^ 4'h1;
            cyc(1);
        end
        chk("refill_count", {29'd0, count}, 4);
        ready = 1'b1; vec = vec ^ 4'h1;
        cyc(1);
        chk("pushpop_count", {29'd0, count}, 4);
        chk("pushpop_ovf", {31'd0, overflow}, 0);
        ready = 1'b0; vec = vec ^ 4'h1; clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("drop_clr_ovf", {31'd0, overflow}, 1);
        chk("drop_clr_count", {29'd0, count}, 4);
        ready = 1'b1;
        cyc(4);
        ready = 1'b0;
        chk("drain2_empty", {29'd0, count}, 0);

        // Disabled changes are never reported later.
        en = 1'b0; vec = 4'h0;
        cyc(1);
        vec = 4'hF;
        cyc(1);
        en = 1'b1;
        cyc(2);
        chk("en_stale_count", {29'd0, count}, 0);
        vec = 4'hE;
        cyc(1);
        chk("en_mask", {28'd0, evt_mask}, 4'h1);
        chk("en_vec", {28'd0, evt_vec}, 4'hE);
        vec = 4'hF;
        cyc(1);
        vec = 4'hE;
        cyc(1);
        chk("three_queued", {29'd0, count}, 3);

        // Asynchronous reset takes effect between edges.
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, evt_valid}, 0);
        chk("async_count", {29'd0, count}, 0);
        cyc(1);
        rst = 1'b0;
        cyc(2);
        chk("post_rst_base", {29'd0, count}, 0);

        // Timestamp wrap: events at ts=255 and ts=1.
        guard = 0;
        while (m_ts != 255 && guard < 400) begin
            cyc(1);
            guard++;
        end
        chk("wrap_reach", {31'd0, m_ts == 255}, 1);
        vec = vec ^ 4'h2;
        cyc(1);
        chk("wrap_ts255", {24'd0, evt_ts}, 255);
        cyc(1);
        vec = vec ^ 4'h2;
        cyc(1);
        chk("wrap_count", {29'd0, count}, 2);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("wrap_ts1", {24'd0, evt_ts}, 1);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vector_change_logger.md
Name: vector_change_logger

Overview:
- Downstream consumer of the 4-bit bit-inverted/pass-through vector stage.
- Samples the vector every clock and detects per-bit changes against the previous sample.
- Pushes each change event into a small show-ahead FIFO. An event is {new vector, change mask, timestamp}.
- Presents events on a valid/ready interface for a trace/debug sink, and flags lost events with a sticky overflow.

Parameters:
WIDTH, 4, width of the monitored vector.
DEPTH, 4, FIFO entries; power of two, >= 2.
TS_WIDTH, 8, width of the free-running timestamp counter.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
en_i  input  1  logging enable; when low, no events are pushed.
vec_i  input  WIDTH  monitored vector (the upstream stage's output).
clr_ovf_i  input  1  clears overflow_o.
evt_ready_i  input  1  sink ready.
evt_valid_o  output  1  event available at FIFO head.
evt_vec_o  output  WIDTH  vector value after the change.
evt_mask_o  output  WIDTH  bits that changed (1 = toggled).
evt_ts_o  output  TS_WIDTH  timestamp of the sampling edge.
overflow_o  output  1  sticky: an event was dropped.
count_o  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async assert, released synchronously to clk_i by the environment):
  - evt_valid_o=0, evt_vec_o=0, evt_mask_o=0, evt_ts_o=0, overflow_o=0, count_o=0.
  - Timestamp counter=0, prev_q=0, primed=0.
  - Reset mid-operation discards all FIFO contents immediately.
- Timestamp: ts_q increments by 1 every cycle; it is not gated by en_i. It wraps from 2^TS_WIDTH-1 to 0.
- Sampling:
  - prev_q <= vec_i every cycle, regardless of en_i.
  - primed <= 1 on the first edge after reset. The first post-reset sample only sets the baseline and never generates an event.
- Change detection: mask = vec_i ^ prev_q, computed per bit.
- Push condition: primed && en_i && (mask != 0). The push writes {vec_i, mask, ts_q} at that edge.
- en_i low:
  - Changes are not logged.
  - prev_q still tracks, so re-enabling never reports a stale change.
- FIFO:
  - Show-ahead: the head entry drives evt_*_o combinationally from storage.
  - evt_valid_o = (count != 0).
  - Pop on evt_valid_o && evt_ready_i.
- Handshake:
  - While evt_valid_o && !evt_ready_i, evt_vec_o/evt_mask_o/evt_ts_o hold stable.
  - evt_valid_o never drops without a pop.
  - The evt_* data outputs are don't-care when evt_valid_o=0.
- Latency: a change present on vec_i at edge N is written at edge N. If the FIFO was empty, evt_valid_o=1 in the cycle after edge N.
- Full (count=DEPTH):
  - Push without pop: the event is dropped and overflow_o <= 1. Occupancy, pointers and stored data are unchanged.
  - Push with pop in the same cycle: both happen; count stays DEPTH and there is no overflow.
- Empty with push: count 0->1; a pop is impossible since valid=0.
- Simultaneous push and pop at nonzero occupancy: count unchanged.
- Pointers: log2(DEPTH) bits each, wrapping naturally. Occupancy is tracked in a separate counter.
- overflow_o:
  - Set by a drop, cleared by clr_ovf_i.
  - If a drop and clr_ovf_i occur in the same cycle, set wins: overflow_o=1.
- evt_ready_i high with the FIFO empty has no effect.

Test Plan:
- Reset, hold vec_i=4'hA for 3 cycles -> no event (baseline only); evt_valid_o=0, count_o=0.
- From vec_i=4'h0, drive 4'h5 at the edge where ts=5, evt_ready_i=0 -> next cycle evt_valid_o=1, evt_vec_o=4'h5, evt_mask_o=4'h5, evt_ts_o=5. The data is held until evt_ready_i=1, then count_o returns to 0.
- With evt_ready_i=0, toggle vec_i on 5 consecutive cycles (DEPTH=4) -> count_o=4, the 5th event is dropped, overflow_o=1. Draining then returns the first four events in order with consecutive timestamps.
- With the FIFO full and evt_ready_i=1 on a change cycle -> the pop and push both occur, count_o stays 4 and overflow_o stays 0. Then pulse clr_ovf_i in the same cycle as a forced drop -> overflow_o remains 1.
- en_i=0 while vec_i goes 4'h0 -> 4'hF, then en_i=1 with vec_i held at 4'hF -> no event is ever logged. A subsequent change to 4'hE logs mask=4'h1.
- Assert rst_i asynchronously with 3 events queued -> evt_valid_o=0 and count_o=0 immediately, without waiting for a clock edge. After release, the first sample is baseline only.
- Timestamp wrap (TS_WIDTH=8) -> an event at ts=255 is followed by an event two cycles later carrying ts=1.
